seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Output stage downstream of the CPU core. Latches a 32-bit value from the CPU (eight hex nibbles) and time-multiplexes it onto an 8-digit common-anode seven-segment display.
- Drives `eight_decode` (segments) and `mie` (digit enables); both are active-low.
- A free-running refresh divider sets the digit dwell time. An optional blanking window at the start of each digit period suppresses ghosting.

Parameters:
- SCAN_DIV, 100000: clock cycles each digit stays enabled. Must be >= 2.
- BLANK_CYCLES, 0: cycles at the start of each digit period with all digits disabled. Must be < SCAN_DIV.
- DIV_W, 17: width of the divider counter. Must satisfy 2^DIV_W >= SCAN_DIV.

Ports:
- clk  in  1: system clock; all logic on the rising edge.
- clear  in  1: synchronous, active-high reset.
- load  in  1: when high at a clock edge, data_in is captured into the shadow register.
- data_in  in  32: value to display. Nibble i (bits 4i+3:4i) appears on digit i.
- eight_decode  out  7: segment drives, active-low. Bit0=a ... bit6=g. Registered.
- mie  out  8: digit enables, active-low. At most one bit is low. Registered.
- scan_idx  out  3: current digit index, for debug and verification. Registered.

Behaviour:
- Reset: clear=1 is sampled at a rising edge; a single sampled edge is sufficient. Registers take these values:
  - div_cnt=0, scan_idx=0, shadow=32'h0.
  - mie=8'hFE, eight_decode=7'h40 (the code for "0").
  - clear has priority over load and over divider advance.
- Divider:
  - div_cnt increments every cycle.
  - When div_cnt==SCAN_DIV-1, div_cnt wraps to 0 and scan_idx increments modulo 8 (7 wraps to 0).
  - One full frame is 8*SCAN_DIV cycles.
- Load:
  - shadow <= data_in on any edge where load=1 and clear=0.
  - load does not touch div_cnt or scan_idx.
  - load is level-sensitive: holding it high re-captures every cycle.
- Output pipeline: at each edge, the outputs are computed from the pre-edge scan_idx, shadow and div_cnt, then registered.
  - mie = ~(8'b1 << scan_idx), except during blanking, when mie = 8'hFF.
  - Blanking is active when div_cnt < BLANK_CYCLES.
  - eight_decode = hex code of shadow nibble scan_idx.
  - Therefore outputs lag internal state by exactly 1 cycle. Segment and enable changes always occur on the same edge.
- Latency:
  - A load at edge N is visible on eight_decode at edge N+1, if that digit is active.
  - A divider wrap at edge N moves mie at edge N+1.
- Hex codes (gfedcba, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Simultaneous events:
  - load together with a divider wrap: both take effect. The new digit shows the new shadow one cycle later.
  - clear together with load: clear wins and shadow=0.
- Reset mid-operation: the scan restarts at digit 0 with div_cnt=0. The previous value is discarded.
- No undefined states: all 8 scan_idx values are legal. BLANK_CYCLES=0 disables blanking entirely.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN.
- When defined (leading-zero suppression):
  - Digit i (i>=1) shows eight_decode=7'h7F (all segments off) if shadow nibbles i..7 are all zero.
  - Digit 0 is never suppressed.
  - mie timing is unchanged, so the enable still pulses low and only the segments are dark.
- When undefined: every digit always shows its hex code.

Test Plan (SCAN_DIV=4, BLANK_CYCLES=0 unless stated):
1. Reset: hold clear=1 for 2 cycles -> mie=8'hFE, eight_decode=7'h40, scan_idx=0. Then release clear; after 4 cycles -> mie=8'hFD.
2. Scan order: load 32'h12345678.
   - Digit 0: seg=7'h00, mie=FE.
   - Digit 1: seg=7'h78, mie=FD.
   - ... up to digit 7: seg=7'h79, mie=7F.
   - Back to FE exactly 32 cycles after the first FE.
3. Decode table: load 32'h76543210 and then 32'hFEDCBA98; check all 16 codes per the table across two frames.
4. Mid-digit load: while scan_idx=3, load 32'h0000A000 -> on the next edge seg=7'h08, and scan_idx/div_cnt are unchanged.
5. Mid-scan clear: assert clear at scan_idx=5 -> at the next edge scan_idx=0, mie=FE, seg=7'h40. The next frame shows zeros.
6. BLANK_CYCLES=1: the first output cycle of every digit has mie=8'hFF and the other 3 cycles are one-hot-low. With SEG7_LZ_BLANK_EN and load 32'h00000305:
   - Digits 3-7: seg=7'h7F.
   - Digit 2: seg=7'h30.
   - Digit 1: seg=7'h40 (shown, because a higher nibble is non-zero).
   - Digit 0: seg=7'h12.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Latches a 32-bit value and time-multiplexes its eight hex nibbles onto an
// 8-digit common-anode seven-segment display. Segment drives (eight_decode)
// and digit enables (mie) are active-low and fully registered, one cycle
// behind the internal scan state so that both always change on the same edge.
//
// Optional build macro:
//   SEG7_LZ_BLANK_EN - leading-zero suppression. Digit i (i >= 1) is shown
//                      dark (7'h7F) when shadow nibbles i..7 are all zero.
//                      Digit 0 is never suppressed; enable timing unchanged.
//
// Parameters:
//   SCAN_DIV     - clock cycles each digit stays enabled (>= 2)
//   BLANK_CYCLES - cycles at the start of each digit period with all digits
//                  disabled (< SCAN_DIV, 0 disables blanking)
//   DIV_W        - divider width, 2**DIV_W >= SCAN_DIV

module seg7_scan_driver #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 0,
    parameter int DIV_W        = 17
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] data_in,
    output logic [6:0]  eight_decode,
    output logic [7:0]  mie,
    output logic [2:0]  scan_idx
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

    localparam logic [7:0] MIE_RESET  = 8'hFE;
    localparam logic [7:0] MIE_BLANK  = 8'hFF;
    localparam logic [6:0] SEG_ZERO   = 7'h40;
    localparam logic [6:0] SEG_DARK   = 7'h7F;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Hex nibble to active-low gfedcba segment pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Select nibble idx out of the 32-bit shadow value.
    function automatic logic [3:0] pick_nibble(input logic [31:0] val,
                                               input logic [2:0]  idx);
        logic [3:0] nib;
        case (idx)
            3'd0:    nib = val[3:0];
            3'd1:    nib = val[7:4];
            3'd2:    nib = val[11:8];
            3'd3:    nib = val[15:12];
            3'd4:    nib = val[19:16];
            3'd5:    nib = val[23:20];
            3'd6:    nib = val[27:24];
            3'd7:    nib = val[31:28];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

`ifdef SEG7_LZ_BLANK_EN
    // True when digit idx is a leading zero: idx >= 1 and every nibble from
    // idx upward is zero. Digit 0 always shows so a zero value reads "0".
    function automatic logic is_leading_zero(input logic [31:0] val,
                                             input logic [2:0]  idx);
        logic [31:0] mask;
        logic        upper_nz;
        mask     = 32'hFFFF_FFFF << {idx, 2'b00};
        upper_nz = |(val & mask);
        return (idx != 3'd0) && !upper_nz;
    endfunction
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_cnt;
    logic [2:0]       r_scan_idx;
    logic [31:0]      r_shadow;
    logic [6:0]       r_seg;
    logic [7:0]       r_mie;

    logic             w_div_wrap;
    logic             w_blank;
    logic [3:0]       w_nibble;
    logic [6:0]       w_seg_next;
    logic [7:0]       w_mie_next;

    // ------------------------------------------------------------------
    // Blanking window decode. With BLANK_CYCLES = 0 the compare would be
    // trivially false, so it is tied off instead of generating a dead
    // unsigned-less-than-zero comparison.
    // ------------------------------------------------------------------
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign w_blank = 1'b0;
        end else begin : g_blank
            assign w_blank = (r_div_cnt < DIV_W'(BLANK_CYCLES));
        end
    endgenerate

    // Divider terminal count: last cycle of the current digit period.
    always_comb begin
        w_div_wrap = (r_div_cnt == DIV_LAST);
    end

    // Refresh divider: counts 0..SCAN_DIV-1 and wraps.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_div_cnt <= DIV_ZERO;
        end else if (w_div_wrap) begin
            r_div_cnt <= DIV_ZERO;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_ONE;
        end
    end

    // Digit index: advances once per divider wrap, 7 wraps naturally to 0.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_scan_idx <= 3'd0;
        end else if (w_div_wrap) begin
            r_scan_idx <= r_scan_idx + 3'd1;
        end else begin
            r_scan_idx <= r_scan_idx;
        end
    end

    // Shadow register: level-sensitive capture of the CPU value.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_shadow <= 32'h0000_0000;
        end else if (load) begin
            r_shadow <= data_in;
        end else begin
            r_shadow <= r_shadow;
        end
    end

    // Next segment pattern from the pre-edge digit index and shadow value.
    always_comb begin
        w_nibble   = pick_nibble(r_shadow, r_scan_idx);
        w_seg_next = hex_to_seg(w_nibble);
`ifdef SEG7_LZ_BLANK_EN
        if (is_leading_zero(r_shadow, r_scan_idx)) begin
            w_seg_next = SEG_DARK;
        end else begin
            w_seg_next = hex_to_seg(w_nibble);
        end
`endif
    end

    // Next digit enable: one-hot-low for the active digit, all off while
    // the anti-ghosting blank window is open.
    always_comb begin
        w_mie_next = MIE_BLANK;
        if (w_blank) begin
            w_mie_next = MIE_BLANK;
        end else begin
            w_mie_next = ~(8'h01 << r_scan_idx);
        end
    end

    // Output registers: segments and enables update together on one edge.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_seg <= SEG_ZERO;
            r_mie <= MIE_RESET;
        end else begin
            r_seg <= w_seg_next;
            r_mie <= w_mie_next;
        end
    end

    // ------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------
    assign eight_decode = r_seg;
    assign mie          = r_mie;
    assign scan_idx     = r_scan_idx;

endmodule
